// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Output vectors are packed as {pc_write, ifid_write, idex_nop, if_flush}.
package hazard_pkg;

    localparam int SB_CW = 3;

    typedef enum logic [2:0] {
        RESET,
        FREEZE,
        REDIRECT,
        STALL,
        BRANCH,
        RUN
    } action_t;

    localparam logic [3:0] OUT_RESET    = 4'b0011;
    localparam logic [3:0] OUT_FREEZE   = 4'b0000;
    localparam logic [3:0] OUT_REDIRECT = 4'b1111;
    localparam logic [3:0] OUT_STALL    = 4'b0010;
    localparam logic [3:0] OUT_BRANCH   = 4'b1101;
    localparam logic [3:0] OUT_RUN      = 4'b1100;

    function automatic logic [3:0] action_outputs(input action_t act);
        logic [3:0] vec;
        case (act)
            RESET:    vec = OUT_RESET;
            FREEZE:   vec = OUT_FREEZE;
            REDIRECT: vec = OUT_REDIRECT;
            STALL:    vec = OUT_STALL;
            BRANCH:   vec = OUT_BRANCH;
            RUN:      vec = OUT_RUN;
            default:  vec = OUT_RESET;
        endcase
        return vec;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register load countdown scoreboard with two busy lookup ports.
// Entry 0 has no storage: register 0 can never be pending.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              issue,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic [REG_AW-1:0] rd_a,
    input  logic [REG_AW-1:0] rd_b,
    output logic              busy_a,
    output logic              busy_b
);

    localparam int NREG = 2 ** REG_AW;

    logic [NREG-1:0] busy_vec;

    assign busy_vec[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NREG; gi++) begin : g_entry
            logic [SB_CW-1:0] cnt_reg;
            logic [SB_CW-1:0] cnt_next;

            // A fresh issue wins over the countdown so a reload restarts the latency.
            always_comb begin
                cnt_next = cnt_reg;
                if (issue && issue_rd == REG_AW'(gi))
                    cnt_next = SB_CW'(LOAD_LAT);
                else if (cnt_reg != '0)
                    cnt_next = cnt_reg - SB_CW'(1);
            end

            always_ff @(posedge clk) begin
                if (rst)
                    cnt_reg <= '0;
                else if (!freeze)
                    cnt_reg <= cnt_next;
            end

            assign busy_vec[gi] = (cnt_reg != '0);
        end
    endgenerate

    assign busy_a = busy_vec[rd_a];
    assign busy_b = busy_vec[rd_b];

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard controller: priority decode of reset/freeze/redirect/stall/branch
// into pipeline enables, plus a saturating data-hazard stall counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_is_load,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_branch,
    input  logic              id_br_taken,
    input  logic              idex_regwrite,
    input  logic [REG_AW-1:0] idex_rd,
    input  logic              dmem_stall,
    input  logic              ex_redirect,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_nop,
    output logic              if_flush,
    output logic [CNT_W-1:0]  stall_cnt
);

    action_t          action;
    logic             busy_rs;
    logic             busy_rt;
    logic             ex_match;
    logic             hazard;
    logic             issue;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] stall_cnt_next;

    hazard_scoreboard #(
        .REG_AW   (REG_AW),
        .LOAD_LAT (LOAD_LAT)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .freeze   (dmem_stall),
        .issue    (issue),
        .issue_rd (id_rd),
        .rd_a     (id_rs),
        .rd_b     (id_rt),
        .busy_a   (busy_rs),
        .busy_b   (busy_rt)
    );

    // Branches resolve in ID, so an EX-stage producer cannot be forwarded to them.
    assign ex_match = idex_regwrite && (idex_rd != '0) &&
                      ((id_uses_rs && idex_rd == id_rs) || (id_uses_rt && idex_rd == id_rt));

    assign hazard = id_valid && ((id_uses_rs && busy_rs) || (id_uses_rt && busy_rt) ||
                                 (id_branch && ex_match));

    always_comb begin
        action = RUN;
        if (rst)
            action = RESET;
        else if (dmem_stall)
            action = FREEZE;
        else if (ex_redirect)
            action = REDIRECT;
        else if (hazard)
            action = STALL;
        else if (id_valid && id_branch && id_br_taken)
            action = BRANCH;
    end

    assign issue = id_valid && id_is_load && (id_rd != '0) &&
                   (action == RUN || action == BRANCH);

    assign {pc_write, ifid_write, idex_nop, if_flush} = action_outputs(action);

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (action == STALL && stall_cnt_reg != '1)
            stall_cnt_next = stall_cnt_reg + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt_reg <= '0;
        else
            stall_cnt_reg <= stall_cnt_next;
    end

    assign stall_cnt = stall_cnt_reg;

endmodule
